// File: rtl/gemm_job_sequencer.sv
// Job controller for the fixed-weight systolic GEMM: loads weight rows, streams vectors, and collects results. A result is sampled 2*SA_SIZE cycles after issue and is out_valid one cycle later.
// Output back-pressure is handled by credits, so no array result is ever dropped. The GEMM_SEQ_PERF_EN macro enables the input-stall counter.
module gemm_job_sequencer #(
    parameter int SA_SIZE                = 4,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int MAX_VECTORS            = 16,
    parameter int OUT_DEPTH              = 8,
    localparam int DW = SA_SIZE * WEIGHT_ACTIVATION_SIZE,
    localparam int NW = $clog2(MAX_VECTORS + 1),
    localparam int RW = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [NW-1:0] cfg_num_vectors,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic [DW-1:0] w_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          sa_w_we,
    output logic [RW-1:0] sa_w_row,
    output logic [DW-1:0] sa_w_data,
    output logic          sa_act_valid,
    output logic [DW-1:0] sa_act_data,
    input  logic [DW-1:0] sa_out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [31:0]   perf_stall_cnt
);
    localparam int LAT = 2 * SA_SIZE;
    localparam int CW  = $clog2(OUT_DEPTH + 1);
    localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SA_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [NW-1:0] num_vec, vec_cnt;
    logic [RW-1:0] row_cnt;
    logic [LAT-1:0] tag_vld, tag_last;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0] fifo_dat [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] fifo_last;

    logic cfg_fire, w_fire, issue, pop, push, is_last;

    assign cfg_fire = cfg_valid & cfg_ready;
    assign w_fire   = w_valid & w_ready;
    assign issue    = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign push     = tag_vld[LAT-1];
    assign is_last  = ((vec_cnt + NW'(1)) == num_vec);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        w_ready   = 1'b0;
        in_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_nxt = S_LOAD_W;
            end
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && row_cnt == ROW_LAST)
                    state_nxt = (num_vec == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                // outstanding counts both array in-flight and FIFO-resident results
                in_ready = (outstanding < DEPTH_C);
                if (in_valid && in_ready && is_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sa_w_we      = w_fire;
    assign sa_w_row     = row_cnt;
    assign sa_w_data    = w_data;
    assign sa_act_valid = issue;
    assign sa_act_data  = in_data;
    assign busy         = (state != S_IDLE);
    assign out_valid    = (fifo_count != '0);
    assign out_data     = fifo_dat[rd_ptr];
    assign out_last     = out_valid & fifo_last[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            num_vec     <= '0;
            vec_cnt     <= '0;
            row_cnt     <= '0;
            tag_vld     <= '0;
            tag_last    <= '0;
            outstanding <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_fire) begin
                num_vec <= cfg_num_vectors;
                vec_cnt <= '0;
                row_cnt <= '0;
            end
            if (w_fire) row_cnt <= row_cnt + RW'(1);
            if (issue)  vec_cnt <= vec_cnt + NW'(1);
            tag_vld  <= {tag_vld[LAT-2:0], issue};
            tag_last <= {tag_last[LAT-2:0], issue & is_last};
            if (issue && !pop)
                outstanding <= outstanding + CNT_ONE;
            else if (pop && !issue)
                outstanding <= outstanding - CNT_ONE;
        end
    end

    // Credits guarantee space, so a tagged result is pushed without checking full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_last  <= '0;
        end else begin
            if (push) begin
                fifo_last[wr_ptr] <= tag_last[LAT-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                fifo_count <= fifo_count + CNT_ONE;
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_dat[wr_ptr] <= sa_out_data;
    end

`ifdef GEMM_SEQ_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (cfg_fire)
            stall_cnt <= '0;
        else if (state == S_STREAM && in_valid && !in_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_gemm_job_sequencer.sv
// Directed bench for gemm_job_sequencer with a fixed-latency array model and a result scoreboard.
module tb_gemm_job_sequencer;
    localparam int SA = 2, EW = 8, DEPTH = 4, MAXV = 16;
    localparam int NW = $clog2(MAXV + 1), DW = SA * EW, LAT = 2 * SA, RW = 1;

    logic          clk = 1'b0, reset = 1'b1;
    logic          cfg_valid = 1'b0, cfg_ready;
    logic [NW-1:0] cfg_num_vectors = '0;
    logic          w_valid = 1'b0, w_ready;
    logic [DW-1:0] w_data = '0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] in_data = '0;
    logic          sa_w_we;
    logic [RW-1:0] sa_w_row;
    logic [DW-1:0] sa_w_data, sa_act_data, sa_out_data, out_data;
    logic          sa_act_valid, out_valid, out_last, busy, done;
    logic          out_ready = 1'b1;
    logic [31:0]   perf_stall_cnt;

    gemm_job_sequencer #(.SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(EW),
                         .MAX_VECTORS(MAXV), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_vectors(cfg_num_vectors), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sa_w_we(sa_w_we), .sa_w_row(sa_w_row), .sa_w_data(sa_w_data),
        .sa_act_valid(sa_act_valid), .sa_act_data(sa_act_data), .sa_out_data(sa_out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // y[r] = sum_c W[r][c] * x[c], mod 2^EW
    function automatic logic [DW-1:0] matvec(input logic [DW-1:0] wm [SA], input logic [DW-1:0] x);
        logic [DW-1:0] y;
        int acc;
        y = '0;
        for (int r = 0; r < SA; r++) begin
            acc = 0;
            for (int c = 0; c < SA; c++)
                acc += int'(wm[r][c*EW +: EW]) * int'(x[c*EW +: EW]);
            y[r*EW +: EW] = EW'(acc);
        end
        return y;
    endfunction

    function automatic logic [DW-1:0] v2(input int a, input int b);
        return {EW'(b), EW'(a)};
    endfunction

    // Array model: result appears on sa_out_data exactly LAT cycles after issue, junk otherwise.
    logic [DW-1:0] arr_w [SA];
    logic [DW-1:0] pipe_d [LAT];
    logic [LAT-1:0] pipe_v;
    always @(posedge clk or posedge reset) begin
        if (reset) pipe_v <= '0;
        else begin
            if (sa_w_we) arr_w[sa_w_row] <= sa_w_data;
            pipe_v    <= {pipe_v[LAT-2:0], sa_act_valid};
            pipe_d[0] <= matvec(arr_w, sa_act_data);
            for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign sa_out_data = pipe_v[LAT-1] ? pipe_d[LAT-1] : 16'hDEAD;

    // Scoreboard state
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] cur_w [SA];
    int cur_n = 0, cur_k = 0;
    int cyc = 0, pop_cnt = 0, issue_cnt = 0, done_cnt = 0, out_model = 0;
    int done_cyc = 0, last_w_cyc = 0, stall_model = 0;
    logic [DW-1:0] last_pop_dat = '0, prev_dat = '0;
    logic last_pop_last = 1'b0, prev_last = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;

    always @(negedge clk) begin
        logic [DW:0] e;
        cyc++;
        if (reset) begin
            exp_q.delete();
            out_model  = 0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) stall_model = 0;
            else if (in_valid && !in_ready) stall_model++;
            chk("act_valid", sa_act_valid, in_valid & in_ready);
            if (in_valid && in_ready) begin
                chk("act_data", sa_act_data, in_data);
                chk("credit_bound", out_model < DEPTH, 1);
                issue_cnt++;
                out_model++;
            end
            if (w_valid && w_ready) last_w_cyc = cyc;
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_dat);
                chk("hold_last", out_last, prev_last);
            end
            if (!out_valid) chk("last_without_valid", out_last, 0);
            if (out_valid && out_ready) begin
                chk("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[DW-1:0]);
                    chk("out_last", out_last, e[DW]);
                end
                pop_cnt++;
                out_model--;
                last_pop_dat  = out_data;
                last_pop_last = out_last;
            end
            if (done) begin
                chk("done_one_cycle", prev_done, 0);
                chk("done_after_results", exp_q.size(), 0);
                done_cnt++;
                done_cyc = cyc;
            end
            prev_done  = done;
            prev_stall = out_valid & !out_ready;
            prev_dat   = out_data;
            prev_last  = out_last;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_job(input logic [DW-1:0] r0, input logic [DW-1:0] r1, input int n);
        int b;
        cfg_valid = 1'b1;
        cfg_num_vectors = NW'(n);
        b = 0;
        @(negedge clk);
        while (!cfg_ready && b < 50) begin @(negedge clk); b++; end
        if (!cfg_ready) chk("cfg_ready_wait", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        cur_w[0] = r0; cur_w[1] = r1; cur_n = n; cur_k = 0;
        for (int r = 0; r < SA; r++) begin
            w_valid = 1'b1;
            w_data  = cur_w[r];
            b = 0;
            @(negedge clk);
            while (!w_ready && b < 50) begin @(negedge clk); b++; end
            if (!w_ready) chk("w_ready_wait", w_ready, 1);
            tick();
            w_valid = 1'b0;
        end
    endtask

    task automatic send_vec(input logic [DW-1:0] x);
        int b;
        in_valid = 1'b1;
        in_data  = x;
        b = 0;
        @(negedge clk);
        while (!in_ready && b < 200) begin @(negedge clk); b++; end
        if (in_ready) begin
            exp_q.push_back({cur_k == cur_n - 1, matvec(cur_w, x)});
            cur_k++;
        end else chk("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        int b = 0;
        while (pop_cnt < target && b < 300) begin @(posedge clk); b++; end
        #1;
        chk("pop_count", pop_cnt, target);
    endtask

    task automatic wait_done(input int target);
        int b = 0;
        while (done_cnt < target && b < 300) begin @(posedge clk); b++; end
        #1;
        chk("done_count", done_cnt, target);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_sa_w_we"}, sa_w_we, 0);
        chk({tag, "_sa_act_valid"}, sa_act_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    logic t7_stop = 1'b0;
    logic [DW-1:0] wd1 [SA];
    logic [DW-1:0] wr0, wr1;
    int p0, d0, i0;

    initial begin
        wd1[0] = v2(3, 0); wd1[1] = v2(0, 2);
        wr0 = wd1[0]; wr1 = wd1[1];
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        chk("reset_perf", perf_stall_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cfg_ready", cfg_ready, 1);
        tick();

        // 1: single vector
        p0 = pop_cnt; d0 = done_cnt;
        start_job(wr0, wr1, 1);
        send_vec(v2(2, 5));
        wait_pops(p0 + 1);
        chk("t1_data", last_pop_dat, 16'h0A06);
        chk("t1_last", last_pop_last, 1);
        wait_done(d0 + 1);

        // 2: two back-to-back vectors
        p0 = pop_cnt; d0 = done_cnt;
        start_job(wr0, wr1, 2);
        send_vec(v2(2, 5));
        send_vec(v2(3, 2));
        wait_pops(p0 + 2);
        chk("t2_data", last_pop_dat, 16'h0409);
        chk("t2_last", last_pop_last, 1);
        wait_done(d0 + 1);

        // 3: credit limit with output stalled
        p0 = pop_cnt; d0 = done_cnt; i0 = issue_cnt;
        out_ready = 1'b0;
        start_job(wr0, wr1, 8);
        fork
            for (int k = 0; k < 8; k++) send_vec(v2(k + 1, 2 * k));
        join_none
        repeat (30) tick();
        chk("t3_issued_at_stall", issue_cnt - i0, DEPTH);
        chk("t3_in_ready_low", in_ready, 0);
        chk("t3_fifo_full_valid", out_valid, 1);
        out_ready = 1'b1;
        wait fork;
        wait_pops(p0 + 8);
        chk("t3_last_data", last_pop_dat, 16'h1C18);
        chk("t3_issued_total", issue_cnt - i0, 8);
`ifdef GEMM_SEQ_PERF_EN
        chk("t3_perf_stalls", perf_stall_cnt, 32'(stall_model));
`else
        chk("t3_perf_zero", perf_stall_cnt, 0);
`endif
        wait_done(d0 + 1);

        // 4: zero-vector job
        p0 = pop_cnt; d0 = done_cnt; i0 = issue_cnt;
        start_job(wr0, wr1, 0);
        wait_done(d0 + 1);
        chk("t4_done_delay", done_cyc - last_w_cyc, 1);
        chk("t4_no_issue", issue_cnt, i0);
        chk("t4_no_result", pop_cnt, p0);

        // 5: reset with three vectors in flight
        start_job(wr0, wr1, 3);
        send_vec(v2(1, 1));
        send_vec(v2(2, 2));
        send_vec(v2(3, 3));
        reset = 1'b1;
        @(negedge clk);
        check_quiet("midreset");
        tick();
        reset = 1'b0;
        p0 = pop_cnt;
        repeat (8) tick();
        chk("t5_no_stale_result", pop_cnt, p0);
        chk("t5_out_valid", out_valid, 0);

        // 7: fresh job after reset with a toggling consumer
        p0 = pop_cnt; d0 = done_cnt;
        start_job(v2(1, 2), v2(3, 4), 6);
        fork
            for (int i = 0; i < 300 && !t7_stop; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
        join_none
        send_vec(v2(1, 1));
        send_vec(v2(2, 0));
        for (int k = 0; k < 4; k++) send_vec(v2($urandom_range(0, 255), $urandom_range(0, 255)));
        wait_pops(p0 + 6);
        t7_stop = 1'b1;
        wait fork;
        out_ready = 1'b1;
        wait_done(d0 + 1);

        // 6: modular wrap
        p0 = pop_cnt; d0 = done_cnt;
        start_job(v2(255, 0), v2(0, 255), 1);
        send_vec(v2(2, 3));
        wait_pops(p0 + 1);
        chk("t6_data", last_pop_dat, 16'hFDFE);
        wait_done(d0 + 1);

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
